// File: rtl/bus_pkg.sv
// Shared bus definitions for the split-capable bus target: widths, rw encoding
// and the target FSM state encoding.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic BUS_RW_WRITE = 1'b1;
  localparam logic BUS_RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_DATA   = 3'd1,
    WR_COMMIT = 3'd2,
    RD_FETCH  = 3'd3,
    SPLIT_REQ = 3'd4,
    RD_RESP   = 3'd5
  } tgt_state_t;

endpackage

// File: rtl/bus_split_target_mem.sv
// Local byte store for bus_split_target: synchronous write, combinational read,
// every byte returns to INIT on reset.
module target_mem
  import bus_pkg::*;
#(
  parameter int                DEPTH = 256,
  parameter logic [DATA_W-1:0] INIT  = 8'h00,
  localparam int               IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array is reset so a reset mid-transaction re-initialises the contents;
  // this forces flops instead of a RAM macro, which is acceptable at these depths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_split_target.sv
// Bus target with local byte memory; reads are answered directly or as split
// transactions. Split behaviour is enabled by defining BUS_SPLIT_TARGET_SPLIT_EN.
module bus_split_target
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'h0000,
  parameter int                MEM_DEPTH       = 256,
  parameter int                READ_LATENCY    = 4,
  parameter int                SPLIT_THRESHOLD = 2,
  parameter logic [DATA_W-1:0] MEM_INIT_DATA   = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] tgt_addr_in,
  input  logic              tgt_addr_in_valid,
  input  logic [DATA_W-1:0] tgt_data_in,
  input  logic              tgt_data_in_valid,
  input  logic              tgt_rw,
  output logic              tgt_ready,
  output logic              tgt_ack,
  output logic              tgt_split_ack,
  output logic [DATA_W-1:0] tgt_data_out,
  output logic              tgt_data_out_valid,
  output logic              split_req,
  input  logic              split_grant
);

  localparam int                IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [7:0]        CNT_INIT = 8'(READ_LATENCY - 1);

`ifdef BUS_SPLIT_TARGET_SPLIT_EN
  localparam bit SPLIT_RD = (READ_LATENCY > SPLIT_THRESHOLD);
`else
  localparam bit SPLIT_RD = 1'b0 && (READ_LATENCY > SPLIT_THRESHOLD);
`endif

  generate
    if (int'(BASE_ADDR) + MEM_DEPTH > 65535) begin : g_bad_range
      $error("bus_split_target: BASE_ADDR + MEM_DEPTH exceeds the 16-bit address space");
    end
    if (MEM_DEPTH < 2 || MEM_DEPTH > 4096 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bus_split_target: MEM_DEPTH must be a power of 2 in 2..4096");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 255) begin : g_bad_latency
      $error("bus_split_target: READ_LATENCY must be in 1..255");
    end
  endgenerate

  // Addresses below BASE_ADDR wrap to a huge 17-bit offset, so one compare decodes the hit.
  logic [ADDR_W:0]    offset;
  logic               hit;
  logic [IDX_W-1:0]   index;

  assign offset = {1'b0, tgt_addr_in} - {1'b0, BASE_ADDR};
  assign hit    = (offset < DEPTH_L);
  assign index  = offset[IDX_W-1:0];

  tgt_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              sack_q, sack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  target_mem #(
    .DEPTH (MEM_DEPTH),
    .INIT  (MEM_INIT_DATA)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

  // NOTE: every always_comb output gets a default up front so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    sack_d   = 1'b0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tgt_addr_in_valid && hit) begin
          idx_d = index;
          if (tgt_rw == BUS_RW_WRITE) begin
            if (tgt_data_in_valid) begin
              wdata_d = tgt_data_in;
              state_d = WR_COMMIT;
            end else begin
              state_d = WR_DATA;
            end
          end else begin
            cnt_d   = CNT_INIT;
            sack_d  = SPLIT_RD;
            state_d = RD_FETCH;
          end
        end
      end
      WR_DATA: begin
        if (tgt_data_in_valid) begin
          wdata_d = tgt_data_in;
          state_d = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        mem_we  = 1'b1;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      RD_FETCH: begin
        if (cnt_q == 8'd0) begin
          if (SPLIT_RD) begin
            state_d = SPLIT_REQ;
          end else begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
            ack_d    = 1'b1;
            state_d  = RD_RESP;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SPLIT_REQ: begin
        if (split_grant) begin
          rdata_d  = mem_rdata;
          rvalid_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= 8'd0;
      ack_q    <= 1'b0;
      sack_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      sack_q   <= sack_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign tgt_ready          = (state_q == IDLE);
  assign tgt_ack            = ack_q;
  assign tgt_split_ack      = sack_q;
  assign tgt_data_out       = rdata_q;
  assign tgt_data_out_valid = rvalid_q;
  assign split_req          = (state_q == SPLIT_REQ);

endmodule

// File: tb/tb_bus_split_target.sv
// Bench for bus_split_target: a cycle-indexed expectation model driven by
// transaction rules, checked every cycle on two differently configured targets.
module tb_bus_split_target;

  localparam int MAXC = 2000;
`ifdef BUS_SPLIT_TARGET_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0] addr [2];
  logic        addr_v [2], rw [2], din_v [2], grant [2];
  logic [7:0]  din [2];
  logic        ready [2], ack [2], sack [2], dout_v [2], sreq [2];
  logic [7:0]  dout [2];

  always #5 clk = ~clk;

  bus_split_target u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .tgt_addr_in(addr[0]), .tgt_addr_in_valid(addr_v[0]),
    .tgt_data_in(din[0]), .tgt_data_in_valid(din_v[0]), .tgt_rw(rw[0]),
    .tgt_ready(ready[0]), .tgt_ack(ack[0]), .tgt_split_ack(sack[0]),
    .tgt_data_out(dout[0]), .tgt_data_out_valid(dout_v[0]),
    .split_req(sreq[0]), .split_grant(grant[0])
  );

  bus_split_target #(.BASE_ADDR(16'h1000), .MEM_DEPTH(16), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .tgt_addr_in(addr[1]), .tgt_addr_in_valid(addr_v[1]),
    .tgt_data_in(din[1]), .tgt_data_in_valid(din_v[1]), .tgt_rw(rw[1]),
    .tgt_ready(ready[1]), .tgt_ack(ack[1]), .tgt_split_ack(sack[1]),
    .tgt_data_out(dout[1]), .tgt_data_out_valid(dout_v[1]),
    .split_req(sreq[1]), .split_grant(grant[1])
  );

  function automatic int base_of(input int d);  return (d == 0) ? 0 : 'h1000; endfunction
  function automatic int depth_of(input int d); return (d == 0) ? 256 : 16;   endfunction
  function automatic int lat_of(input int d);   return (d == 0) ? 4 : 1;      endfunction

  // Expected outputs per DUT per cycle, plus a byte-level memory image.
  bit         e_ready [2][MAXC], e_ack [2][MAXC], e_sack [2][MAXC];
  bit         e_sreq [2][MAXC], e_valid [2][MAXC];
  logic [7:0] e_data [2][MAXC];
  logic [7:0] mem_m [2][256];

  int n_vec = 0, n_err = 0, cyc = 0;
  bit chk_en = 1'b0;
  int last_ack [2], n_sack [2], n_sreq_rise [2];
  logic [7:0] last_rd [2];
  bit sreq_prev [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset(input int from);
    for (int d = 0; d < 2; d++) begin
      for (int c = from; c < MAXC; c++) begin
        e_ready[d][c] = 1'b1; e_ack[d][c] = 1'b0; e_sack[d][c] = 1'b0;
        e_sreq[d][c]  = 1'b0; e_valid[d][c] = 1'b0; e_data[d][c] = 8'h00;
      end
      for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
    end
  endfunction

  function automatic bit hit(input int d, input int a);
    return (a >= base_of(d)) && (a < base_of(d) + depth_of(d));
  endfunction

  function automatic void busy(input int d, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) e_ready[d][c] = 1'b0;
  endfunction

  function automatic void respond(input int d, input int c, input logic [7:0] v);
    e_ack[d][c] = 1'b1; e_valid[d][c] = 1'b1;
    for (int k = c; k < MAXC; k++) e_data[d][k] = v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (chk_en && cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d ready", d),      ready[d],  e_ready[d][cyc]);
        check($sformatf("dut%0d ack", d),        ack[d],    e_ack[d][cyc]);
        check($sformatf("dut%0d split_ack", d),  sack[d],   e_sack[d][cyc]);
        check($sformatf("dut%0d split_req", d),  sreq[d],   e_sreq[d][cyc]);
        check($sformatf("dut%0d data_valid", d), dout_v[d], e_valid[d][cyc]);
        check($sformatf("dut%0d data_out", d),   dout[d],   e_data[d][cyc]);
      end
    end
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ack[d] === 1'b1) last_ack[d] = cyc;
        if (dout_v[d] === 1'b1) last_rd[d] = dout[d];
        if (sack[d] === 1'b1) n_sack[d]++;
        if (sreq[d] === 1'b1 && !sreq_prev[d]) n_sreq_rise[d]++;
        sreq_prev[d] = (sreq[d] === 1'b1);
      end
    end
  end

  task automatic do_write(input int d, input logic [15:0] a, input logic [7:0] v,
                          input int gap, output int t);
    int td;
    @(negedge clk);
    t = cyc; td = t + gap;
    addr[d] = a; addr_v[d] = 1'b1; rw[d] = 1'b1;
    if (gap == 0) begin din[d] = v; din_v[d] = 1'b1; end
    if (hit(d, int'(a))) begin
      busy(d, t + 1, td + 1);
      e_ack[d][td + 2] = 1'b1;
      mem_m[d][int'(a) - base_of(d)] = v;
    end
    @(negedge clk);
    addr_v[d] = 1'b0; din_v[d] = 1'b0;
    if (gap > 0) begin
      while (cyc < td) @(negedge clk);
      din[d] = v; din_v[d] = 1'b1;
      @(negedge clk);
      din_v[d] = 1'b0;
    end
    while (cyc <= td + 2) @(negedge clk);
  endtask

  // gdly: cycles between split_req rising and the grant; inj: push a beat while busy.
  task automatic do_read(input int d, input logic [15:0] a, input int gdly,
                         input bit inj, output int t);
    int r, g, ac;
    bit sp;
    @(negedge clk);
    t = cyc;
    addr[d] = a; addr_v[d] = 1'b1; rw[d] = 1'b0;
    sp = SPLIT_ON && (lat_of(d) > 2);
    r  = t + lat_of(d) + 1;
    g  = r + gdly;
    ac = sp ? g + 1 : r;
    if (hit(d, int'(a))) begin
      busy(d, t + 1, ac);
      if (sp) begin
        e_sack[d][t + 1] = 1'b1;
        for (int c = r; c <= g; c++) e_sreq[d][c] = 1'b1;
      end
      respond(d, ac, mem_m[d][int'(a) - base_of(d)]);
    end
    @(negedge clk);
    addr_v[d] = 1'b0;
    if (inj) begin
      @(negedge clk);
      addr[d] = 16'h0060 + 16'(base_of(d)); rw[d] = 1'b1; din[d] = 8'h99;
      addr_v[d] = 1'b1; din_v[d] = 1'b1;
      @(negedge clk);
      addr_v[d] = 1'b0; din_v[d] = 1'b0;
    end
    while (cyc < g) @(negedge clk);
    grant[d] = 1'b1;
    @(negedge clk);
    grant[d] = 1'b0;
    while (cyc <= ac + 1) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check($sformatf("%s dut%0d ready", tag, d),      ready[d],  1);
    check($sformatf("%s dut%0d ack", tag, d),        ack[d],    0);
    check($sformatf("%s dut%0d split_ack", tag, d),  sack[d],   0);
    check($sformatf("%s dut%0d split_req", tag, d),  sreq[d],   0);
    check($sformatf("%s dut%0d data_valid", tag, d), dout_v[d], 0);
    check($sformatf("%s dut%0d data_out", tag, d),   dout[d],   8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, rc;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; addr_v[d] = 0; rw[d] = 0; din[d] = '0; din_v[d] = 0; grant[d] = 0;
      last_ack[d] = -1; n_sack[d] = 0; n_sreq_rise[d] = 0; last_rd[d] = 8'hxx; sreq_prev[d] = 0;
    end
    model_reset(0);
    #3;
    check_reset_outputs(0, "reset");
    check_reset_outputs(1, "reset");
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Write with address and data together, then write with data trailing by 3 cycles.
    do_write(0, 16'h0012, 8'h5A, 0, t);
    check("wr same-cycle ack latency", last_ack[0] - t, 2);
    do_write(0, 16'h0034, 8'hA7, 3, t);
    check("wr late-data ack latency", last_ack[0] - t, 5);

    // Reads: written byte with delayed grant, unwritten byte, and a beat injected while busy.
    do_read(0, 16'h0012, 3, 1'b0, t);
    check("rd 0x12 data", last_rd[0], 8'h5A);
    check("rd 0x12 ack latency", last_ack[0] - t, SPLIT_ON ? 9 : 5);
    check("rd 0x12 split_ack pulses", n_sack[0], SPLIT_ON ? 1 : 0);
    check("rd 0x12 split_req rises", n_sreq_rise[0], SPLIT_ON ? 1 : 0);
    do_read(0, 16'h0050, 3, 1'b1, t);
    check("rd unwritten data", last_rd[0], 8'h00);
    do_read(0, 16'h0034, 0, 1'b0, t);
    check("rd 0x34 data", last_rd[0], 8'hA7);
    check("rd 0x34 ack latency", last_ack[0] - t, SPLIT_ON ? 6 : 5);
    check("data_out holds", dout[0], 8'hA7);
    do_read(0, 16'h0060, 0, 1'b0, t);
    check("dropped beat not written", last_rd[0], 8'h00);

    // Top-of-window hit versus the first miss above it.
    do_write(0, 16'h0100, 8'hFF, 0, t);
    do_write(0, 16'h00FF, 8'h3C, 0, t);
    do_read(0, 16'h00FF, 1, 1'b0, t);
    check("rd 0xFF data", last_rd[0], 8'h3C);
    do_read(0, 16'h0000, 1, 1'b0, t);
    check("miss did not alias index 0", last_rd[0], 8'h00);

    // Offset window with single-cycle read latency.
    do_write(1, 16'h100F, 8'h81, 0, t);
    do_read(1, 16'h100F, 0, 1'b0, t);
    check("lat1 rd data", last_rd[1], 8'h81);
    check("lat1 rd ack latency", last_ack[1] - t, 2);
    do_write(1, 16'h1010, 8'hEE, 0, t);
    do_write(1, 16'h0FFF, 8'hDD, 0, t);
    do_write(1, 16'h1000, 8'h42, 1, t);
    do_read(1, 16'h1000, 0, 1'b0, t);
    check("lat1 base data", last_rd[1], 8'h42);
    check("lat1 split_ack never", n_sack[1], 0);

    // Reset while a read is in flight (waiting for grant when splits are enabled).
    do_write(0, 16'h0020, 8'hC3, 0, t);
    @(negedge clk);
    t = cyc;
    addr[0] = 16'h0020; addr_v[0] = 1'b1; rw[0] = 1'b0;
    rc = SPLIT_ON ? t + lat_of(0) + 3 : t + 3;
    busy(0, t + 1, rc);
    if (SPLIT_ON) begin
      e_sack[0][t + 1] = 1'b1;
      for (int c = t + lat_of(0) + 1; c <= rc; c++) e_sreq[0][c] = 1'b1;
    end
    @(negedge clk);
    addr_v[0] = 1'b0;
    while (cyc < rc) @(negedge clk);
    check("pre-reset ready", ready[0], 0);
    check("pre-reset split_req", sreq[0], SPLIT_ON);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs(0, "mid-read reset");
    check_reset_outputs(1, "mid-read reset");
    model_reset(cyc);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (6) @(negedge clk);
    check("no ack after reset release", last_ack[0] > rc, 0);
    do_read(0, 16'h0020, 0, 1'b0, t);
    check("memory re-initialised", last_rd[0], 8'h00);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_split_target.md
Name: bus_split_target

Overview:
- Bus-side target that sits directly downstream of the bus initiator, behind the bus mux/arbiter.
- Captures the address, write data and rw strobe the initiator drives across the bus, and commits writes into a local byte memory.
- Serves reads either immediately or as a split transaction: it releases the bus with split_ack, then re-requests the bus to return the data with ack.
- Produces the ack, split_ack and read-data signals that the initiator consumes.

Parameters:
- BASE_ADDR, 16'h0000, first bus address decoded by this target.
- MEM_DEPTH, 256, number of bytes in the local memory; must be a power of 2, max 4096.
- READ_LATENCY, 4, cycles from read-address capture until read data is ready; range 1..255.
- SPLIT_THRESHOLD, 2; a read splits when READ_LATENCY > SPLIT_THRESHOLD.
- MEM_INIT_DATA, 8'h00, reset value of every memory byte.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- tgt_addr_in, input, 16, bus address.
- tgt_addr_in_valid, input, 1, address qualifier, single-cycle beat.
- tgt_data_in, input, 8, bus write data.
- tgt_data_in_valid, input, 1, write-data qualifier.
- tgt_rw, input, 1, 1 = write, 0 = read; sampled together with the address beat.
- tgt_ready, output, 1, high when the target can accept a new address.
- tgt_ack, output, 1, one-cycle pulse: write committed, or read data valid.
- tgt_split_ack, output, 1, one-cycle pulse: read accepted and bus released.
- tgt_data_out, output, 8, read data.
- tgt_data_out_valid, output, 1, qualifier for tgt_data_out.
- split_req, output, 1, request to the arbiter to resume a split read.
- split_grant, input, 1, arbiter grant for the split resume.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - tgt_ready = 1.
  - tgt_ack, tgt_split_ack, tgt_data_out_valid, split_req all 0.
  - tgt_data_out = 0.
  - All memory bytes = MEM_INIT_DATA; latency counter = 0.
- Decode:
  - hit = BASE_ADDR <= addr < BASE_ADDR+MEM_DEPTH.
  - index = (addr - BASE_ADDR), truncated to $clog2(MEM_DEPTH) bits.
  - Miss: the beat is ignored; no ack, no state change.
- IDLE:
  - tgt_ready = 1.
  - Address beat that hits with tgt_rw = 1: latch index, go to WR_DATA. If tgt_data_in_valid is high in the same cycle, also latch the data and go to WR_COMMIT.
  - Address beat that hits with tgt_rw = 0: latch index, load counter = READ_LATENCY - 1, go to RD_FETCH.
- WR_DATA:
  - tgt_ready = 0.
  - On tgt_data_in_valid: latch data, go to WR_COMMIT.
  - Data arriving earlier than the address is not supported; the initiator drives both on the same granted cycle or data later.
- WR_COMMIT:
  - Write mem[index] <= data.
  - Pulse tgt_ack on the next cycle. Write latency = 2 cycles from the address beat to the ack.
  - Go to IDLE.
- RD_FETCH:
  - tgt_ready = 0.
  - If READ_LATENCY > SPLIT_THRESHOLD: pulse tgt_split_ack in the first RD_FETCH cycle.
  - Counter decrements once per cycle. At 0, go to RD_RESP when non-split, or to SPLIT_REQ when split.
- SPLIT_REQ:
  - Hold split_req = 1 until split_grant is sampled high, then deassert split_req and go to RD_RESP.
  - split_grant arriving in the same cycle split_req first rises is valid.
- RD_RESP:
  - tgt_data_out = mem[index]; tgt_data_out_valid = 1 and tgt_ack = 1 for exactly one cycle.
  - Then tgt_data_out_valid = 0, tgt_data_out holds its value, go to IDLE.
- Boundary cases:
  - An address beat while tgt_ready = 0 is dropped (the arbiter must not grant during this time).
  - READ_LATENCY = 1: RD_FETCH lasts one cycle, so read ack arrives 2 cycles after the address beat.
  - Address beat exactly at BASE_ADDR+MEM_DEPTH-1 hits; beat at BASE_ADDR+MEM_DEPTH misses.
  - 16-bit wrap: BASE_ADDR+MEM_DEPTH > 16'hFFFF is illegal; flag it with an elaboration assertion.
  - Reset mid-split: split_req drops immediately (async), no ack is emitted, memory is re-initialised.

Optional Feature:
- Macro: BUS_SPLIT_TARGET_SPLIT_EN.
- Defined: split behaviour as above.
- Undefined: tgt_split_ack and split_req are tied to 0, split_grant is ignored, and SPLIT_REQ is never entered. All reads stall in RD_FETCH while holding the bus, then go to RD_RESP, so read ack arrives READ_LATENCY+1 cycles after the address beat.

Decomposition:
- Package bus_pkg:
  - tgt_state_t enum (IDLE, WR_DATA, WR_COMMIT, RD_FETCH, SPLIT_REQ, RD_RESP).
  - Constants BUS_RW_WRITE = 1'b1, BUS_RW_READ = 1'b0.
  - Bus widths ADDR_W = 16, DATA_W = 8.
- One sub-module, target_mem:
  - Byte array, synchronous write, combinational read, async-reset initialisation.
  - The FSM stays in bus_split_target.

Test Plan:
- Write 8'h5A to 16'h0012, address and data in the same cycle -> tgt_ack pulses 2 cycles later; a later read of 16'h0012 returns 8'h5A.
- Write address 16'h0034 with data 3 cycles later -> tgt_ready = 0 while waiting; ack follows the data by 2 cycles; mem[0x34] = data.
- Split read (READ_LATENCY = 4, macro defined) from an unwritten byte:
  - tgt_split_ack pulses 1 cycle after the address beat; split_req rises 4 cycles later.
  - With split_grant delayed 3 cycles: ack + valid for 1 cycle with data 8'h00.
- Same read with the macro undefined -> no split_ack, no split_req; ack + valid 5 cycles after the address beat.
- Address 16'h0100 with BASE_ADDR = 0, MEM_DEPTH = 256 -> no response, tgt_ready stays 1; address 16'h00FF hits.
- Assert rst_n low while split_req = 1 -> all outputs return to reset values immediately; no ack after release.
